// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W     = 11;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_MEM_ADDR_W = 7;

  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  typedef struct packed {
    owner_t owner;
    logic   is_read;
    logic   oor;
  } resp_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied debug cycles; force_dbg asks the
// arbiter to put the debug port ahead of the CPU for one cycle.
module arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] dbg_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_wait <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      dbg_wait <= '0;
    end else if (dbg_wait != CW'(STARVE_MAX)) begin
      dbg_wait <= dbg_wait + 1'b1;
    end
  end

  always_comb begin
    force_dbg = (dbg_wait == CW'(STARVE_MAX));
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of the single-port data memory.
// Define ARB_STARVE_GUARD_EN to add the debug starvation guard.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_wren,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     mem_q,
  output logic                  oor_err
);

  logic              force_dbg;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;
  resp_t             resp_d;
  resp_t             resp_q;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .dbg_req   (dbg_req),
    .dbg_gnt   (dbg_gnt),
    .force_dbg (force_dbg)
  );
`else
  assign force_dbg = 1'b0;
`endif

  // Grants are gated by rst_n so nothing is issued while reset is held.
  always_comb begin
    dbg_gnt = rst_n & dbg_req & (~cpu_req | force_dbg);
    cpu_gnt = rst_n & cpu_req & ~dbg_gnt;
    any_gnt = cpu_gnt | dbg_gnt;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (dbg_gnt) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
    sel_oor  = |sel_addr[ADDR_W-1:MEM_ADDR_W];
    mem_addr = sel_addr[MEM_ADDR_W-1:0];
    mem_data = sel_wdata;
    mem_wren = any_gnt & sel_we & ~sel_oor;
  end

  always_comb begin
    resp_d.owner   = dbg_gnt ? OWN_DBG : OWN_CPU;
    resp_d.is_read = any_gnt & ~sel_we;
    resp_d.oor     = any_gnt & sel_oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q  <= '0;
      oor_err <= 1'b0;
    end else begin
      resp_q <= resp_d;
      if (any_gnt && sel_oor) begin
        oor_err <= 1'b1;
      end
    end
  end

  always_comb begin
    cpu_rvalid = resp_q.is_read && (resp_q.owner == OWN_CPU);
    dbg_rvalid = resp_q.is_read && (resp_q.owner == OWN_DBG);
    cpu_rdata  = (cpu_rvalid && !resp_q.oor) ? mem_q : '0;
    dbg_rdata  = (dbg_rvalid && !resp_q.oor) ? mem_q : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural data_mem.
module tb_data_mem_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [10:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_wren;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data, mem_q;
  logic        oor_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  data_mem_arbiter #(
    .ADDR_W (11), .DATA_W (32), .MEM_ADDR_W (7), .STARVE_MAX (4)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_gnt (cpu_gnt), .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
    .dbg_req (dbg_req), .dbg_we (dbg_we), .dbg_addr (dbg_addr), .dbg_wdata (dbg_wdata),
    .dbg_gnt (dbg_gnt), .dbg_rvalid (dbg_rvalid), .dbg_rdata (dbg_rdata),
    .mem_wren (mem_wren), .mem_addr (mem_addr), .mem_data (mem_data), .mem_q (mem_q),
    .oor_err (oor_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [10:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [10:0] a, input logic [31:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic idle();
    drive_cpu(1'b0, 1'b0, 11'd0, 32'd0);
    drive_dbg(1'b0, 1'b0, 11'd0, 32'd0);
  endtask

  task automatic do_write(input bit use_dbg, input logic [10:0] a, input logic [31:0] d);
    if (use_dbg) drive_dbg(1'b1, 1'b1, a, d);
    else         drive_cpu(1'b1, 1'b1, a, d);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cpu(1'b1, 1'b1, 11'd3, 32'hFFFF_FFFF);
    drive_dbg(1'b1, 1'b1, 11'd4, 32'hFFFF_FFFF);
    #3;
    checks++; if (cpu_gnt !== 1'b0) begin failures++; $display("FAIL reset_cpu_gnt got=%b exp=0", cpu_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin failures++; $display("FAIL reset_dbg_gnt got=%b exp=0", dbg_gnt); end
    checks++; if ({mem_wren, mem_addr, mem_data} !== '0) begin failures++;
      $display("FAIL reset_mem_bus got wren=%b addr=%h data=%h exp all 0", mem_wren, mem_addr, mem_data); end
    checks++; if ({cpu_rvalid, dbg_rvalid, oor_err} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got rv=%b%b oor=%b exp 000", cpu_rvalid, dbg_rvalid, oor_err); end
    checks++; if ({cpu_rdata, dbg_rdata} !== 64'd0) begin failures++;
      $display("FAIL reset_rdata got %h %h exp 0", cpu_rdata, dbg_rdata); end
    idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    drive_cpu(1'b1, 1'b1, 11'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL wr_cpu_gnt got=%b exp=1", cpu_gnt); end
    checks++; if ({mem_wren, mem_addr, mem_data} !== {1'b1, 7'd5, 32'hDEAD_BEEF}) begin failures++;
      $display("FAIL wr_mem_bus got wren=%b addr=%h data=%h exp 1/05/deadbeef", mem_wren, mem_addr, mem_data); end
    tick();
    drive_cpu(1'b1, 1'b0, 11'd5, 32'd0);
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL rd_cpu_gnt got=%b exp=1", cpu_gnt); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL rd_mem_wren got=%b exp=0", mem_wren); end
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", cpu_rvalid); end
    tick();
    idle();
    #1;
    checks++; if (cpu_rvalid !== 1'b1) begin failures++; $display("FAIL rd_cpu_rvalid got=%b exp=1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_cpu_rdata got=%h exp=deadbeef", cpu_rdata); end
    checks++; if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL rd_dbg_rvalid got=%b exp=0", dbg_rvalid); end
    tick();
  endtask

  task automatic test_interleave();
    do_write(1'b0, 11'd1, 32'h11);
    do_write(1'b1, 11'd2, 32'h22);
    drive_cpu(1'b1, 1'b0, 11'd1, 32'd0);
    tick();
    idle();
    drive_dbg(1'b1, 1'b0, 11'd2, 32'd0);
    #1;
    checks++; if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL il_dbg_gnt got=%b exp=1", dbg_gnt); end
    checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b10) begin failures++;
      $display("FAIL il_rvalid1 got cpu=%b dbg=%b exp 1/0", cpu_rvalid, dbg_rvalid); end
    checks++; if (cpu_rdata !== 32'h11) begin failures++; $display("FAIL il_cpu_rdata got=%h exp=11", cpu_rdata); end
    tick();
    idle();
    #1;
    checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b01) begin failures++;
      $display("FAIL il_rvalid2 got cpu=%b dbg=%b exp 0/1", cpu_rvalid, dbg_rvalid); end
    checks++; if ({dbg_rdata, cpu_rdata} !== {32'h22, 32'h0}) begin failures++;
      $display("FAIL il_dbg_rdata got dbg=%h cpu=%h exp 22/0", dbg_rdata, cpu_rdata); end
    tick();
  endtask

  task automatic test_oor();
    do_write(1'b0, 11'd0, 32'hA5A5_A5A5);
    drive_dbg(1'b1, 1'b1, 11'h080, 32'h1234);
    #1;
    checks++; if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL oor_dbg_gnt got=%b exp=1", dbg_gnt); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL oor_mem_wren got=%b exp=0", mem_wren); end
    tick();
    idle();
    #1;
    checks++; if (oor_err !== 1'b1) begin failures++; $display("FAIL oor_err_set got=%b exp=1", oor_err); end
    drive_cpu(1'b1, 1'b0, 11'd0, 32'd0);
    tick();
    idle();
    #1;
    checks++; if (cpu_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL oor_mem0_kept got=%h exp=a5a5a5a5", cpu_rdata); end
    drive_dbg(1'b1, 1'b0, 11'h080, 32'd0);
    tick();
    idle();
    #1;
    checks++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'd0}) begin failures++;
      $display("FAIL oor_read got rv=%b data=%h exp 1/0", dbg_rvalid, dbg_rdata); end
    checks++; if (oor_err !== 1'b1) begin failures++; $display("FAIL oor_err_sticky got=%b exp=1", oor_err); end
    tick();
  endtask

  task automatic test_starve();
    int first_dbg = 0;
    int dbg_count = 0;
    drive_cpu(1'b1, 1'b0, 11'd1, 32'd0);
    drive_dbg(1'b1, 1'b0, 11'd2, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++; if ((cpu_gnt ^ dbg_gnt) !== 1'b1) begin failures++;
        $display("FAIL starve_one_gnt cyc=%0d got cpu=%b dbg=%b exp exactly one", i, cpu_gnt, dbg_gnt); end
      if (dbg_gnt === 1'b1) begin
        dbg_count++;
        if (first_dbg == 0) first_dbg = i;
      end
      tick();
      if (first_dbg != 0) drive_dbg(1'b0, 1'b0, 11'd0, 32'd0);
    end
    checks++; if (first_dbg != (GUARD ? 5 : 0)) begin failures++;
      $display("FAIL starve_first_dbg got=%0d exp=%0d", first_dbg, GUARD ? 5 : 0); end
    checks++; if (dbg_count != (GUARD ? 1 : 0)) begin failures++;
      $display("FAIL starve_dbg_count got=%0d exp=%0d", dbg_count, GUARD ? 1 : 0); end
    idle();
    tick();
  endtask

  task automatic test_pulse();
    int first_dbg = 0;
    drive_cpu(1'b1, 1'b0, 11'd1, 32'd0);
    drive_dbg(1'b1, 1'b0, 11'd2, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dbg_gnt !== 1'b0) begin failures++; $display("FAIL pulse_no_gnt cyc=%0d got=%b exp=0", i, dbg_gnt); end
      tick();
    end
    drive_dbg(1'b0, 1'b0, 11'd0, 32'd0);
    tick();
    drive_dbg(1'b1, 1'b0, 11'd2, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (dbg_gnt === 1'b1 && first_dbg == 0) first_dbg = i;
      tick();
      if (first_dbg != 0) drive_dbg(1'b0, 1'b0, 11'd0, 32'd0);
    end
    checks++; if (first_dbg != (GUARD ? 5 : 0)) begin failures++;
      $display("FAIL pulse_wait_cleared first_dbg got=%0d exp=%0d", first_dbg, GUARD ? 5 : 0); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive_cpu(1'b1, 1'b0, 11'd5, 32'h5555_AAAA);
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL rm_cpu_gnt got=%b exp=1", cpu_gnt); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({cpu_gnt, cpu_rvalid, dbg_rvalid, oor_err, mem_wren} !== 5'b0) begin failures++;
      $display("FAIL rm_flags got gnt=%b rv=%b%b oor=%b wren=%b exp 0", cpu_gnt, cpu_rvalid, dbg_rvalid, oor_err, mem_wren); end
    checks++; if ({mem_addr, mem_data, cpu_rdata} !== '0) begin failures++;
      $display("FAIL rm_data got addr=%h data=%h rdata=%h exp 0", mem_addr, mem_data, cpu_rdata); end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rm_no_rvalid got=%b exp=0", cpu_rvalid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_interleave();
    test_oor();
    test_starve();
    test_pulse();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
